// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared definitions for the Hack hardware platform datapath blocks.
//   WORD_W    : native data word width of the platform (16 bits)
//   word_t    : one data word, bit 15 is the MSB / two's-complement sign bit
//   ZERO_WORD : all-zero word, the default reset value for word registers
// -----------------------------------------------------------------------------
package hack_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t ZERO_WORD = 16'h0000;

endpackage : hack_pkg

// File: rtl/and1.sv
// -----------------------------------------------------------------------------
// and1
// Single-bit AND built from two NAND cells: the first NAND forms ~(a & b),
// the second NAND has both inputs tied together and acts as an inverter.
// A 0 on either input forces the first NAND to 1 and therefore y to 0, even
// when the other input is unknown.
// Ports:
//   a, b : inputs
//   y    : a & b
// -----------------------------------------------------------------------------
module and1 (
    input  logic a,
    input  logic b,
    output logic y
);

    logic nand_ab;

    nand2 u_nand (
        .a (a),
        .b (b),
        .y (nand_ab)
    );

    // NAND with both inputs tied is a NOT gate.
    nand2 u_not (
        .a (nand_ab),
        .b (nand_ab),
        .y (y)
    );

endmodule : and1

// File: rtl/nand2.sv
// -----------------------------------------------------------------------------
// nand2
// Two-input NAND, the single primitive that the Hack gate library is built
// from. Every other gate in the library is composed of instances of this cell.
// Ports:
//   a, b : inputs
//   y    : ~(a & b)
// -----------------------------------------------------------------------------
module nand2 (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a & b);

endmodule : nand2

// File: rtl/and16.sv
// -----------------------------------------------------------------------------
// and16
// 16-bit bitwise AND of the Hack platform, assembled from sixteen and1 cells.
// The combinational result is presented with zero latency on out; a registered
// copy with a valid flag is provided for pipelined consumers (ALU, CPU).
// Parameters:
//   WIDTH     : bus width, only 16 is accepted
//   RESET_VAL : value loaded into out_q while reset is asserted
// Ports:
//   clk       : clock, all registers update on its rising edge
//   reset     : synchronous, active-high reset
//   in_a      : operand A
//   in_b      : operand B
//   out       : in_a & in_b, combinational, unaffected by reset
//   out_q     : in_a & in_b sampled at the previous rising edge
//   out_valid : high once out_q holds a result sampled since reset
// -----------------------------------------------------------------------------
module and16
    import hack_pkg::*;
#(
    parameter int    WIDTH     = WORD_W,
    parameter word_t RESET_VAL = ZERO_WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid
);

    // The gate is defined for the platform word only.
    generate
        if (WIDTH != WORD_W) begin : g_bad_width
            $error("and16: WIDTH must be 16");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Combinational path: one and1 cell per bit, no behavioural AND here.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] and_w;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            and1 u_and1 (
                .a (in_a[i]),
                .b (in_b[i]),
                .y (and_w[i])
            );
        end
    endgenerate

    assign out = and_w;

    // -------------------------------------------------------------------------
    // Registered copy. The load value is the same gate-level result that
    // drives out, so both paths always agree bit for bit.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] out_d;
    logic             valid_d;
    logic             valid_q;

    always_comb begin
        out_d   = and_w;
        valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;

endmodule : and16

// File: tb/tb_and16.sv
// -----------------------------------------------------------------------------
// tb_and16
// Self-checking bench for and16: a vector table for the combinational path,
// hand-written reset sequences for the registered path, and randomized traffic
// checked against a bit-level reference model and an expected-value queue.
// -----------------------------------------------------------------------------
module tb_and16;

    localparam int W = 16;

    // ---------------------------------------------------------------- clock/reset
    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] out;
    logic [W-1:0] out_q;
    logic         out_valid;

    always #5 clk = ~clk;

    and16 dut (
        .clk       (clk),
        .reset     (reset),
        .in_a      (in_a),
        .in_b      (in_b),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    // ---------------------------------------------------------------- scoreboard
    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_valid_q[$];

    // Reference model: each result bit is 1 exactly when both operand bits are 1,
    // evaluated one bit at a time with plain arithmetic.
    function automatic logic [W-1:0] ref_and(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i] == 1'b1 && b[i] == 1'b1) r = r + (W'(1) << i);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Registered-path model: valid only after a non-reset edge.
    logic model_valid = 1'b0;

    // Drive one cycle of stimulus at the falling edge, check the combinational
    // output shortly after, then check the registered outputs after the rising edge.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic rst,
                        input string name);
        logic [W-1:0] e;
        logic         ev;
        @(negedge clk);
        in_a  = a;
        in_b  = b;
        reset = rst;
        #1;
        check({name, "_out"}, out, ref_and(a, b));
        if (rst) begin
            exp_q.push_back(16'h0000);
            model_valid = 1'b0;
        end else begin
            exp_q.push_back(ref_and(a, b));
            model_valid = 1'b1;
        end
        exp_valid_q.push_back(model_valid);
        @(posedge clk);
        #1;
        e  = exp_q.pop_front();
        ev = exp_valid_q.pop_front();
        check({name, "_out_q"}, out_q, e);
        check({name, "_valid"}, {15'd0, out_valid}, {15'd0, ev});
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        in_a  = '0;
        in_b  = '0;
        reset = 1'b1;

        vecs.push_back('{16'h0805, 16'h0818, 16'h0800});
        vecs.push_back('{16'h860D, 16'h8C45, 16'h8405});
        vecs.push_back('{16'hFFFF, 16'hA5C3, 16'hA5C3});
        vecs.push_back('{16'h5555, 16'hAAAA, 16'h0000});
        vecs.push_back('{16'h0000, 16'h1234, 16'h0000});
        vecs.push_back('{16'h3C96, 16'h3C96, 16'h3C96});
        vecs.push_back('{16'h3C96, 16'hC369, 16'h0000});
        vecs.push_back('{16'h8000, 16'hFFFF, 16'h8000});
        vecs.push_back('{16'h7FFF, 16'h8000, 16'h0000});

        // Reset held for 2 cycles with all-ones operands.
        step(16'hFFFF, 16'hFFFF, 1'b1, "rst0");
        step(16'hFFFF, 16'hFFFF, 1'b1, "rst1");
        // Deassert: one edge loads the result and raises valid.
        step(16'hFFFF, 16'hFFFF, 1'b0, "deassert");
        // Reassert mid-stream: next edge clears out_q and valid.
        step(16'hFFFF, 16'hFFFF, 1'b1, "reassert");
        step(16'h0F0F, 16'h00FF, 1'b0, "restart");

        // Table-driven vectors, also checked through the register.
        foreach (vecs[i]) begin
            @(negedge clk);
            in_a  = vecs[i].a;
            in_b  = vecs[i].b;
            reset = 1'b0;
            #1;
            check($sformatf("vec%0d", i), out, vecs[i].exp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_q", i), out_q, vecs[i].exp);
        end

        // Signed reading of the sign-bit vector.
        @(negedge clk);
        in_a = 16'h860D;
        in_b = 16'h8C45;
        #1;
        checks++;
        if ($signed(out) != -31739) begin
            errors++;
            $display("FAIL signed_out actual=%0d required=%0d", $signed(out), -31739);
        end

        // Walking-one: bit i only in both operands.
        for (int i = 0; i < W; i++) begin
            step(W'(1) << i, W'(1) << i, 1'b0, $sformatf("walk%0d", i));
        end

        // Randomized traffic with occasional mid-stream reset.
        for (int n = 0; n < 300; n++) begin
            step(W'($urandom), W'($urandom), ($urandom_range(0, 15) == 0),
                 $sformatf("rand%0d", n));
        end

        // Boundary identities on random operands.
        for (int n = 0; n < 20; n++) begin
            logic [W-1:0] x;
            x = W'($urandom);
            @(negedge clk);
            reset = 1'b0;
            in_a = 16'hFFFF; in_b = x; #1; check("ones_and_x", out, x);
            in_a = 16'h0000; in_b = x; #1; check("zero_and_x", out, 16'h0000);
            in_a = x;        in_b = x; #1; check("x_and_x", out, x);
            in_a = x;        in_b = ~x; #1; check("x_and_notx", out, 16'h0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_and16
